data_loader_buffered: RTL and testbench

// - Single-clock successor loader: accepts 32-bit bridge writes already in clk_memory domain, queues them in a FIFO, serialises each into 4/2/1 memory words.
// - Two pacing modes: fixed delay (MODE_ACK=0) or per-beat write_ack handshake (MODE_ACK=1).
// - Drops on overflow and raises a sticky overflow flag.
// - Sits between the bridge CDC stage and a memory/SDRAM write port.

---
 rtl/data_loader_buffered_pkg.sv | 24 ++
 rtl/data_loader_buffered_if.sv | 35 +++
 rtl/data_loader_buffered_sync_fifo.sv | 73 +++++++
 rtl/data_loader_buffered.sv | 213 +++++++++++++++++++++
 tb/tb_data_loader_buffered.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_loader_buffered_pkg.sv
// Shared types and helpers for the buffered data loader.
//   loader_state_t : serialiser state encoding (IDLE=0, ISSUE=1, WAIT=2)
//   WORD_BYTES     : bytes in one queued bridge word
//   byte_reverse   : converts a big-endian bridge word to little-endian order
//   is_pow2        : parameter sanity helper for the FIFO depth
package data_loader_buffered_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } loader_state_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] byte_reverse(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/data_loader_buffered_if.sv
// Bridge-write / memory-write bundle of the buffered data loader.
//   in_wr, in_endian_little, in_addr, in_data : bridge write (already in memory clock domain)
//   write_ack                                 : memory accepted the current beat (ack mode)
//   write_en, write_addr, write_data          : memory beat
//   busy, overflow                            : status
// master drives the bridge side, slave is the loader itself.
interface data_loader_buffered_if
    import data_loader_buffered_pkg::*;
#(
    parameter int ADDRESS_SIZE     = 14,
    parameter int OUTPUT_WORD_SIZE = 1
);

    logic                            in_wr;
    logic                            in_endian_little;
    logic [31:0]                     in_addr;
    logic [31:0]                     in_data;
    logic                            write_ack;
    logic                            write_en;
    logic [ADDRESS_SIZE:0]           write_addr;
    logic [8*OUTPUT_WORD_SIZE-1:0]   write_data;
    logic                            busy;
    logic                            overflow;

    modport master (
        output in_wr, in_endian_little, in_addr, in_data, write_ack,
        input  write_en, write_addr, write_data, busy, overflow
    );

    modport slave (
        input  in_wr, in_endian_little, in_addr, in_data, write_ack,
        output write_en, write_addr, write_data, busy, overflow
    );

endinterface

// File: rtl/data_loader_buffered_sync_fifo.sv
// Single-clock FIFO used to queue bridge words ahead of the serialiser.
//   clk, rst          : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data   : enqueue; ignored when full unless a pop happens in the same cycle
//   pop, pop_data     : dequeue; pop_data is the head entry, taken from the storage registers
//   full, empty, count: occupancy, derived from a registered entry count
module data_loader_buffered_sync_fifo
    import data_loader_buffered_pkg::*;
#(
    parameter int WIDTH = 47,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] COUNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] COUNT_ZERO = (PW+1)'(0);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: popping empty is a no-op, pushing full needs a simultaneous pop.
    always_comb begin
        pop_ok_s  = pop && (count_r != COUNT_ZERO);
        push_ok_s = push && ((count_r != COUNT_FULL) || pop_ok_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == COUNT_FULL);
    assign empty    = (count_r == COUNT_ZERO);
    assign count    = count_r;

endmodule

// File: rtl/data_loader_buffered.sv
// Buffered data loader: queues 32-bit bridge writes that hit this loader's
// address window and serialises each into 4/2/1 memory beats.
//   clk_memory : single clock
//   reset      : asynchronous, active-high; empties the queue and abandons any partly sent word
//   bus        : slave side of data_loader_buffered_if (bridge write in, memory beat out,
//                busy / sticky overflow status)
// Pacing is either a fixed beat period (MODE_ACK=0) or a write_ack handshake (MODE_ACK=1).
module data_loader_buffered
    import data_loader_buffered_pkg::*;
#(
    parameter int ADDRESS_MASK_UPPER_4      = 0,
    parameter int ADDRESS_SIZE              = 14,
    parameter int OUTPUT_WORD_SIZE          = 1,
    parameter int FIFO_DEPTH                = 4,
    parameter int MODE_ACK                  = 0,
    parameter int WRITE_MEM_CLOCK_DELAY     = 10,
    parameter int WRITE_MEM_EN_CYCLE_LENGTH = 1
) (
    input  logic                  clk_memory,
    input  logic                  reset,
    data_loader_buffered_if.slave bus
);

    localparam int              AW     = ADDRESS_SIZE + 1;
    localparam int              DW     = 8 * OUTPUT_WORD_SIZE;
    localparam int              EW     = AW + 32;
    localparam int              FAW    = $clog2(FIFO_DEPTH);
    localparam int              CW     = $clog2(WRITE_MEM_CLOCK_DELAY + 1) + 1;
    localparam logic [2:0]      BEATS  = 3'(WORD_BYTES / OUTPUT_WORD_SIZE);
    localparam logic [CW-1:0]   EN_LEN = CW'(WRITE_MEM_EN_CYCLE_LENGTH);
    localparam logic [CW-1:0]   DELAY  = CW'(WRITE_MEM_CLOCK_DELAY);
    localparam logic [3:0]      MASK   = 4'(ADDRESS_MASK_UPPER_4);
    localparam logic [AW-1:0]   STEP   = AW'(OUTPUT_WORD_SIZE);

    // Parameter sanity, rejected at elaboration.
    if (OUTPUT_WORD_SIZE != 1 && OUTPUT_WORD_SIZE != 2 && OUTPUT_WORD_SIZE != 4) begin : g_bad_ows
        $error("data_loader_buffered: OUTPUT_WORD_SIZE must be 1, 2 or 4");
    end
    if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $error("data_loader_buffered: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (WRITE_MEM_EN_CYCLE_LENGTH < 1 || WRITE_MEM_CLOCK_DELAY < WRITE_MEM_EN_CYCLE_LENGTH) begin : g_bad_delay
        $error("data_loader_buffered: need 1 <= WRITE_MEM_EN_CYCLE_LENGTH <= WRITE_MEM_CLOCK_DELAY");
    end
    if (ADDRESS_SIZE > 27) begin : g_bad_asize
        $error("data_loader_buffered: ADDRESS_SIZE must leave in_addr[31:28] for the window select");
    end

    loader_state_t   state_r;
    logic            write_en_r;
    logic [AW-1:0]   write_addr_r;
    logic [DW-1:0]   write_data_r;
    logic [31:0]     shift_r;
    logic [2:0]      k_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            overflow_r;

    logic            addr_match_s;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic [EW-1:0]   push_entry_s;
    logic [EW-1:0]   head_entry_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [FAW:0]    fifo_count_s;
    logic [FAW:0]    count_next_s;
    logic            beat_end_s;
    logic            last_beat_s;
    logic            idle_next_s;
    logic            busy_next_s;
    logic [31:0]     shift_next_s;
    logic            unused_addr_bits_s;

    // Address bits between the window select and the write address carry no meaning here.
    assign unused_addr_bits_s = ^bus.in_addr[27:AW];

    // Decode the bridge write and build the queued entry in little-endian byte order.
    always_comb begin
        addr_match_s = bus.in_wr && (bus.in_addr[31:28] == MASK);
        if (bus.in_endian_little) begin
            push_entry_s = {bus.in_addr[AW-1:0], bus.in_data};
        end else begin
            push_entry_s = {bus.in_addr[AW-1:0], byte_reverse(bus.in_data)};
        end
    end

    // Beat completion, pop decision and next-cycle occupancy used for busy.
    always_comb begin
        beat_end_s = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                if (MODE_ACK != 0) begin
                    beat_end_s = bus.write_ack;
                end else begin
                    // With equal lengths there is no WAIT phase: the beat ends in ISSUE.
                    beat_end_s = (cnt_r == EN_LEN) && (EN_LEN == DELAY);
                end
            end
            ST_WAIT: beat_end_s = (cnt_r == DELAY);
            default: beat_end_s = 1'b0;
        endcase

        last_beat_s = ((k_r + 3'd1) == BEATS);

        // The next word is taken straight after the last beat, so there is no idle bubble.
        if (state_r == ST_IDLE) begin
            pop_s = !fifo_empty_s;
        end else if (beat_end_s && last_beat_s) begin
            pop_s = !fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end

        // A full queue still takes a write when the serialiser frees a slot this cycle.
        push_s = addr_match_s && (!fifo_full_s || pop_s);
        drop_s = addr_match_s && fifo_full_s && !pop_s;

        count_next_s = fifo_count_s + (FAW+1)'(push_s) - (FAW+1)'(pop_s);
        idle_next_s  = ((state_r == ST_IDLE) || (beat_end_s && last_beat_s)) && !pop_s;
        busy_next_s  = !idle_next_s || (count_next_s != (FAW+1)'(0));

        shift_next_s = shift_r >> DW;
    end

    data_loader_buffered_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_memory),
        .rst       (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Serialiser FSM with registered beat outputs and status flags.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_en_r   <= 1'b0;
            write_addr_r <= AW'(0);
            write_data_r <= DW'(0);
            shift_r      <= 32'd0;
            k_r          <= 3'd0;
            cnt_r        <= CW'(0);
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end

            if (pop_s) begin
                // Load a new word; its first beat starts next cycle.
                state_r      <= ST_ISSUE;
                write_en_r   <= 1'b1;
                write_addr_r <= head_entry_s[EW-1:32];
                shift_r      <= head_entry_s[31:0];
                write_data_r <= head_entry_s[DW-1:0];
                k_r          <= 3'd0;
                cnt_r        <= CW'(1);
            end else if (beat_end_s) begin
                if (last_beat_s) begin
                    state_r    <= ST_IDLE;
                    write_en_r <= 1'b0;
                end else begin
                    // Address advances by one beat width and wraps with the address width.
                    state_r      <= ST_ISSUE;
                    write_en_r   <= 1'b1;
                    write_addr_r <= write_addr_r + STEP;
                    shift_r      <= shift_next_s;
                    write_data_r <= shift_next_s[DW-1:0];
                    k_r          <= k_r + 3'd1;
                    cnt_r        <= CW'(1);
                end
            end else begin
                case (state_r)
                    ST_ISSUE: begin
                        // In ack mode the beat is simply held until write_ack.
                        if (MODE_ACK == 0) begin
                            if (cnt_r == EN_LEN) begin
                                state_r    <= ST_WAIT;
                                write_en_r <= 1'b0;
                            end
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_WAIT: begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        write_en_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.write_en   = write_en_r;
    assign bus.write_addr = write_addr_r;
    assign bus.write_data = write_data_r;
    assign bus.busy       = busy_r;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_data_loader_buffered.sv
// Directed bench for data_loader_buffered: three configurations share one clock and reset.
//   u0: OWS=1, fixed pacing 10/1   u1: OWS=2, fixed pacing 4/2   u2: OWS=4, ack pacing
module tb_data_loader_buffered;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    data_loader_buffered_if #(.ADDRESS_SIZE(14), .OUTPUT_WORD_SIZE(1)) if0 ();
    data_loader_buffered_if #(.ADDRESS_SIZE(14), .OUTPUT_WORD_SIZE(2)) if1 ();
    data_loader_buffered_if #(.ADDRESS_SIZE(14), .OUTPUT_WORD_SIZE(4)) if2 ();

    data_loader_buffered #(
        .ADDRESS_MASK_UPPER_4(0), .ADDRESS_SIZE(14), .OUTPUT_WORD_SIZE(1), .FIFO_DEPTH(4),
        .MODE_ACK(0), .WRITE_MEM_CLOCK_DELAY(10), .WRITE_MEM_EN_CYCLE_LENGTH(1)
    ) u0 (.clk_memory(clk), .reset(rst), .bus(if0));

    data_loader_buffered #(
        .ADDRESS_MASK_UPPER_4(0), .ADDRESS_SIZE(14), .OUTPUT_WORD_SIZE(2), .FIFO_DEPTH(4),
        .MODE_ACK(0), .WRITE_MEM_CLOCK_DELAY(4), .WRITE_MEM_EN_CYCLE_LENGTH(2)
    ) u1 (.clk_memory(clk), .reset(rst), .bus(if1));

    data_loader_buffered #(
        .ADDRESS_MASK_UPPER_4(0), .ADDRESS_SIZE(14), .OUTPUT_WORD_SIZE(4), .FIFO_DEPTH(4),
        .MODE_ACK(1), .WRITE_MEM_CLOCK_DELAY(10), .WRITE_MEM_EN_CYCLE_LENGTH(1)
    ) u2 (.clk_memory(clk), .reset(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One little-endian word 0x44332211 through u0; beats every 10 cycles, one byte each.
    task automatic ows1_word(input string tag, input logic [31:0] a);
        int nw;
        logic [14:0] ea;
        logic [7:0]  ed;
        nw = 0;
        if0.in_wr = 1'b1;
        if0.in_addr = a;
        if0.in_data = 32'h4433_2211;
        if0.in_endian_little = 1'b1;
        tick();
        if0.in_wr = 1'b0;
        check({tag, "_en_n1"}, 64'(if0.write_en), 64'd0);
        check({tag, "_busy_n1"}, 64'(if0.busy), 64'd1);
        tick();
        for (int c = 0; c <= 40; c++) begin
            if (if0.write_en) begin
                if (nw < 4) begin
                    ea = a[14:0] + 15'(nw);
                    ed = 8'((nw + 1) * 17);
                    check({tag, "_cycle"}, 64'(c), 64'(10 * nw));
                    check({tag, "_addr"}, 64'(if0.write_addr), 64'(ea));
                    check({tag, "_data"}, 64'(if0.write_data), 64'(ed));
                end
                nw++;
            end
            if (c == 39) check({tag, "_busy_last"}, 64'(if0.busy), 64'd1);
            if (c == 40) check({tag, "_busy_done"}, 64'(if0.busy), 64'd0);
            if (c < 40) tick();
        end
        check({tag, "_beats"}, 64'(nw), 64'd4);
    endtask

    initial begin
        int nw;
        int seen;
        logic expect_en;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        if0.in_wr = 1'b0; if0.in_endian_little = 1'b0; if0.in_addr = 32'd0; if0.in_data = 32'd0; if0.write_ack = 1'b0;
        if1.in_wr = 1'b0; if1.in_endian_little = 1'b0; if1.in_addr = 32'd0; if1.in_data = 32'd0; if1.write_ack = 1'b0;
        if2.in_wr = 1'b0; if2.in_endian_little = 1'b0; if2.in_addr = 32'd0; if2.in_data = 32'd0; if2.write_ack = 1'b0;
        repeat (3) tick();
        check("rst_en", 64'(if0.write_en), 64'd0);
        check("rst_addr", 64'(if0.write_addr), 64'd0);
        check("rst_data", 64'(if0.write_data), 64'd0);
        check("rst_busy", 64'(if0.busy), 64'd0);
        check("rst_ovf", 64'(if2.overflow), 64'd0);
        rst = 1'b0;
        tick();

        // Byte beats at 0x100..0x103, little-endian.
        ows1_word("ows1", 32'h0000_0100);

        // Big-endian, 16-bit beats, 2-cycle strobe every 4 cycles.
        if1.in_wr = 1'b1; if1.in_addr = 32'h0000_0100; if1.in_data = 32'h4433_2211; if1.in_endian_little = 1'b0;
        tick();
        if1.in_wr = 1'b0;
        check("ows2_en_n1", 64'(if1.write_en), 64'd0);
        tick();
        for (int c = 0; c <= 8; c++) begin
            expect_en = (c == 0) || (c == 1) || (c == 4) || (c == 5);
            check("ows2_en", 64'(if1.write_en), 64'(expect_en));
            if (expect_en && c < 4) begin
                check("ows2_addr0", 64'(if1.write_addr), 64'h100);
                check("ows2_data0", 64'(if1.write_data), 64'h3344);
            end
            if (expect_en && c >= 4) begin
                check("ows2_addr1", 64'(if1.write_addr), 64'h102);
                check("ows2_data1", 64'(if1.write_data), 64'h1122);
            end
            if (c == 7) check("ows2_busy_last", 64'(if1.busy), 64'd1);
            if (c == 8) check("ows2_busy_done", 64'(if1.busy), 64'd0);
            if (c < 8) tick();
        end

        // Ack mode: ack while idle is ignored; then a 32-bit beat held until ack.
        if2.write_ack = 1'b1;
        tick();
        if2.write_ack = 1'b0;
        check("ack_idle_en", 64'(if2.write_en), 64'd0);
        check("ack_idle_busy", 64'(if2.busy), 64'd0);
        if2.in_wr = 1'b1; if2.in_addr = 32'h0000_0200; if2.in_data = 32'hA1B2_C3D4; if2.in_endian_little = 1'b1;
        tick();
        if2.in_wr = 1'b0;
        tick();
        for (int c = 0; c <= 5; c++) begin
            check("ack_en", 64'(if2.write_en), 64'd1);
            check("ack_addr", 64'(if2.write_addr), 64'h200);
            check("ack_data", 64'(if2.write_data), 64'hA1B2_C3D4);
            if (c == 5) if2.write_ack = 1'b1;
            tick();
        end
        if2.write_ack = 1'b0;
        check("ack_en_after", 64'(if2.write_en), 64'd0);
        check("ack_busy_after", 64'(if2.busy), 64'd0);

        // Overflow: 6 back-to-back writes with ack low, one in flight + 4 queued, 6th dropped.
        for (int i = 0; i < 6; i++) begin
            if2.in_wr = 1'b1;
            if2.in_addr = 32'h0000_0300 + 32'(16 * i);
            if2.in_data = 32'hC0DE_0000 + 32'(i);
            if2.in_endian_little = 1'b1;
            tick();
            if (i == 4) check("ovf_before", 64'(if2.overflow), 64'd0);
        end
        if2.in_wr = 1'b0;
        check("ovf_set", 64'(if2.overflow), 64'd1);
        check("ovf_busy", 64'(if2.busy), 64'd1);
        if2.write_ack = 1'b1;
        nw = 0;
        for (int c = 0; c < 8; c++) begin
            if (if2.write_en) begin
                if (nw < 5) begin
                    check("ovf_addr", 64'(if2.write_addr), 64'(15'h300 + 15'(16 * nw)));
                    check("ovf_data", 64'(if2.write_data), 64'(32'hC0DE_0000 + 32'(nw)));
                end
                nw++;
            end
            tick();
        end
        if2.write_ack = 1'b0;
        check("ovf_words", 64'(nw), 64'd5);
        check("ovf_busy_done", 64'(if2.busy), 64'd0);
        check("ovf_sticky", 64'(if2.overflow), 64'd1);

        // Writes outside the address window have no effect.
        if0.in_wr = 1'b1; if0.in_addr = 32'h1000_0000; if0.in_data = 32'h1234_5678; if0.in_endian_little = 1'b1;
        tick();
        if0.in_wr = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (if0.write_en || if0.busy) seen++;
            tick();
        end
        check("mask_activity", 64'(seen), 64'd0);
        check("mask_ovf", 64'(if0.overflow), 64'd0);

        // Address wrap at the top of a 15-bit space.
        ows1_word("wrap", 32'h0000_7FFF);

        // Reset during beat 2 with two words queued.
        if0.in_wr = 1'b1; if0.in_addr = 32'h0000_0500; if0.in_data = 32'h4433_2211; if0.in_endian_little = 1'b1;
        tick();
        if0.in_addr = 32'h0000_0600;
        tick();
        check("rmid_first", 64'(if0.write_en), 64'd1);
        if0.in_addr = 32'h0000_0700;
        tick();
        if0.in_wr = 1'b0;
        repeat (9) tick();
        check("rmid_beat2_en", 64'(if0.write_en), 64'd1);
        check("rmid_beat2_addr", 64'(if0.write_addr), 64'h501);
        rst = 1'b1;
        #1;
        check("rmid_en", 64'(if0.write_en), 64'd0);
        check("rmid_addr", 64'(if0.write_addr), 64'd0);
        check("rmid_data", 64'(if0.write_data), 64'd0);
        check("rmid_busy", 64'(if0.busy), 64'd0);
        check("rmid_ovf_cleared", 64'(if2.overflow), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (if0.write_en) seen++;
            tick();
        end
        check("rpost_quiet", 64'(seen), 64'd0);
        check("rpost_busy", 64'(if0.busy), 64'd0);
        if0.in_wr = 1'b1; if0.in_addr = 32'h0000_0040; if0.in_data = 32'h4433_2211; if0.in_endian_little = 1'b1;
        tick();
        if0.in_wr = 1'b0;
        tick();
        check("rpost_new_en", 64'(if0.write_en), 64'd1);
        check("rpost_new_addr", 64'(if0.write_addr), 64'h40);
        check("rpost_new_data", 64'(if0.write_data), 64'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
